// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Package uart_rx_pkg: shared types and constants for the UART RX frame
// controller.
//   rx_state_e         - frame FSM states
//   PRESCALE_8/16/32   - the only oversampling ratios the receiver accepts
//   is_legal_prescale  - returns 1 for a supported prescale value
//   DEF_DATA_WIDTH     - default number of data bits per frame
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam int DEF_DATA_WIDTH = 8;

  function automatic logic is_legal_prescale(input logic [5:0] ps);
    return (ps == PRESCALE_8) || (ps == PRESCALE_16) || (ps == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Interface bundling the frame controller's line, configuration, sampler
// and byte-output signals.
//   master : the frame controller (drives the sampler controls and outputs)
//   slave  : the environment (line, config, sampler results, byte consumer)
// Optional macro UART_RX_BREAK_DETECT_EN adds the break_det signal.
interface uart_rx_frame_ctrl_if #(parameter int DATA_WIDTH = 8);
  logic                  rx_in;
  logic [5:0]            prescale;
  logic                  par_en;
  logic                  par_typ;
  logic                  sampled_bit;
  logic                  sample_done;
  logic                  data_sampled_en;
  logic [5:0]            edge_cnt;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                  break_det;
`endif

  modport master (
    input  rx_in, prescale, par_en, par_typ, sampled_bit, sample_done,
    output data_sampled_en, edge_cnt, p_data, data_valid, par_err, stp_err
`ifdef UART_RX_BREAK_DETECT_EN
    , output break_det
`endif
  );

  modport slave (
    output rx_in, prescale, par_en, par_typ, sampled_bit, sample_done,
    input  data_sampled_en, edge_cnt, p_data, data_valid, par_err, stp_err
`ifdef UART_RX_BREAK_DETECT_EN
    , input break_det
`endif
  );
endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and data-bit counter for the UART RX frame.
//   clk, rst  - clock, async active-low reset
//   en        - count edges (frame in progress)
//   clr       - synchronous clear of both counters (wins over en)
//   bit_adv   - advance the bit counter at this bit's end (DATA bits only)
//   prescale  - oversampling ratio; bit end at edge_cnt == prescale-1
//   edge_cnt  - edge index within the current bit
//   bit_end   - last oversample edge of the current bit
//   last_bit  - bit counter is on the final data bit
module uart_rx_edge_bit_counter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       bit_adv,
  input  logic [5:0] prescale,
  output logic [5:0] edge_cnt,
  output logic       bit_end,
  output logic       last_bit
);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [BW-1:0] bit_cnt;

  assign bit_end  = en && (edge_cnt == (prescale - 6'd1));
  assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (en) begin
      edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
      if (bit_end && bit_adv)
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller. Detects the start bit, walks
// START/DATA/[PARITY]/STOP, deserializes LSB-first from the majority
// sampler's results and reports one pulse per frame end.
//   clk, rst  - oversampling clock, async active-low reset
//   bus       - uart_rx_frame_ctrl_if.master: rx_in, prescale, par_en,
//               par_typ, sampled_bit, sample_done in; data_sampled_en,
//               edge_cnt, p_data, data_valid, par_err, stp_err out
// Optional macro UART_RX_BREAK_DETECT_EN: all-zero data with a zero stop bit
// pulses break_det instead of stp_err/par_err.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  uart_rx_frame_ctrl_if.master bus
);
  rx_state_e             state, state_n;
  logic                  legal, bit_end, last_bit, cnt_en, cnt_clr;
  logic                  accept, taken, bit_q, cur_bit, frame_end;
  logic                  par_bad, stop_bad, perr, brk, frame_ok;
  logic [5:0]            edge_cnt;
  logic [DATA_WIDTH-1:0] sr, p_data_q;
  logic                  data_valid_q, par_err_q, stp_err_q;

  assign legal   = is_legal_prescale(bus.prescale);
  assign cnt_en  = (state != ST_IDLE);
  // Counters sit at zero in IDLE and whenever we are about to fall back to it.
  assign cnt_clr = (state == ST_IDLE) || (state_n == ST_IDLE);

  uart_rx_edge_bit_counter #(.DATA_WIDTH(DATA_WIDTH)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .bit_adv  (state == ST_DATA),
    .prescale (bus.prescale),
    .edge_cnt (edge_cnt),
    .bit_end  (bit_end),
    .last_bit (last_bit)
  );

  // Only the first sample_done of a bit counts; a bit that ends with no
  // sample at all is taken as 0.
  assign accept  = bus.sample_done && !taken && cnt_en;
  assign cur_bit = accept ? bus.sampled_bit : (taken && bit_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    frame_end = 1'b0;
    case (state)
      ST_IDLE:   if (!bus.rx_in && legal) state_n = ST_START;
      ST_START:  if (accept && bus.sampled_bit) state_n = ST_IDLE;
                 else if (bit_end)              state_n = ST_DATA;
      ST_DATA:   if (bit_end && last_bit) state_n = bus.par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_n = ST_STOP;
      ST_STOP:   if (bit_end) begin
                   frame_end = 1'b1;
                   state_n   = bus.rx_in ? ST_IDLE : ST_START;
                 end
      default:   state_n = ST_IDLE;
    endcase
    // Prescale going illegal mid-frame aborts silently.
    if (state != ST_IDLE && !legal) begin
      state_n   = ST_IDLE;
      frame_end = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taken   <= 1'b0;
      bit_q   <= 1'b0;
      sr      <= '0;
      par_bad <= 1'b0;
    end else begin
      if (cnt_clr || bit_end) taken <= 1'b0;
      else if (accept)        taken <= 1'b1;
      if (accept) bit_q <= bus.sampled_bit;
      if (state == ST_DATA && bit_end) sr <= {cur_bit, sr[DATA_WIDTH-1:1]};
      if (state == ST_START)
        par_bad <= 1'b0;
      else if (state == ST_PARITY && bit_end)
        par_bad <= ((^sr) ^ bus.par_typ) != cur_bit;
    end
  end

  assign stop_bad = !cur_bit;
  assign perr     = bus.par_en && par_bad;
  assign frame_ok = !stop_bad && !perr;
`ifdef UART_RX_BREAK_DETECT_EN
  logic break_q;
  assign brk = (sr == '0) && stop_bad;
`else
  assign brk = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      break_q      <= 1'b0;
`endif
    end else begin
      data_valid_q <= frame_end && frame_ok;
      par_err_q    <= frame_end && perr && !brk;
      stp_err_q    <= frame_end && stop_bad && !brk;
`ifdef UART_RX_BREAK_DETECT_EN
      break_q      <= frame_end && brk;
`endif
      if (frame_end && frame_ok) p_data_q <= sr;
    end
  end

  assign bus.edge_cnt        = edge_cnt;
  assign bus.data_sampled_en = cnt_en;
  assign bus.p_data          = p_data_q;
  assign bus.data_valid      = data_valid_q;
  assign bus.par_err         = par_err_q;
  assign bus.stp_err         = stp_err_q;
`ifdef UART_RX_BREAK_DETECT_EN
  assign bus.break_det       = break_q;
`endif
endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Frame controller for the UART receive path. It sits beside the 3-sample majority sampler: it drives that sampler's data_sampled_en and edge_cnt, and consumes its sampled_bit/done outputs.
- Detects the start bit and walks the frame: START, DATA, optional PARITY, STOP.
- Deserializes the data LSB-first and checks the start glitch, parity and stop bit.
- Presents a parallel byte with a one-cycle data_valid strobe to the RX clock-domain consumer.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (LSB first).

Ports:
clk  input  1  oversampling clock (prescale x baud).
rst  input  1  asynchronous active-low reset.
rx_in  input  1  serial line, idle high.
prescale  input  6  oversampling ratio; legal values are 8, 16, 32 only.
par_en  input  1  1 = frame carries a parity bit.
par_typ  input  1  0 = even parity, 1 = odd parity.
sampled_bit  input  1  majority-voted bit from the sampler.
sample_done  input  1  sampler done; sampled_bit is valid in cycles where this is 1.
data_sampled_en  output  1  enables the sampler; high in every non-IDLE state.
edge_cnt  output  6  oversample edge index within the current bit, 0..prescale-1.
p_data  output  DATA_WIDTH  received byte; updated only together with data_valid.
data_valid  output  1  one-cycle pulse: error-free frame available on p_data.
par_err  output  1  one-cycle pulse at frame end: parity mismatch.
stp_err  output  1  one-cycle pulse at frame end: stop bit sampled 0.

Behaviour:
- Clock, reset and ports:
  - One clock domain (clk). Reset rst is asynchronous, active-low.
  - Reset values: state=IDLE, edge_cnt=0, bit counter=0, shift register=0, p_data=0. data_sampled_en, data_valid, par_err and stp_err are all 0.
- States: IDLE, START, DATA, PARITY, STOP (encoding in package).
- Counters:
  - edge_cnt increments every cycle while not IDLE.
  - Bit end is the cycle where edge_cnt==prescale-1; edge_cnt wraps to 0 on the next edge.
  - Bit counter (0..DATA_WIDTH-1) advances at DATA bit ends only.
- IDLE:
  - data_sampled_en=0, edge_cnt held at 0.
  - rx_in==0 with legal prescale -> START next cycle, with edge_cnt=0 and data_sampled_en=1.
  - rx_in==0 with illegal prescale -> stay IDLE.
- START:
  - In the cycle sample_done==1, sampled_bit==1 is a false start -> IDLE next cycle, with no pulses and counters cleared.
  - Otherwise, at bit end -> DATA.
- DATA:
  - In the cycle sample_done==1, shift sampled_bit in at MSB and shift right, so the first received bit ends at bit 0.
  - At bit end of bit DATA_WIDTH-1 -> PARITY if par_en, else STOP.
- PARITY:
  - On sample_done, set the internal parity-error flag = (XOR of the data bits ^ par_typ) != sampled_bit.
  - At bit end -> STOP.
- STOP:
  - On sample_done, capture stop_ok = sampled_bit.
  - At bit end, pulse for exactly one cycle:
    - par_err (when par_en=1 and parity was bad);
    - stp_err (when stop_ok=0);
    - data_valid with p_data <= shift register, only if neither error occurred.
  - p_data holds on an errored frame.
  - Next state is IDLE, or START directly if rx_in==0 in that same bit-end cycle (back-to-back frames, no gap cycle).
- sample_done:
  - At most one sample_done is taken per bit.
  - A sample_done in IDLE is ignored.
  - If a bit ends without sample_done, that bit is treated as sampled 0 (shift 0; stop -> stp_err).
- Mid-frame change: prescale must be stable during a frame. If it becomes illegal mid-frame, abort to IDLE next cycle with no pulses.
- Reset mid-frame: immediate return to reset values; the partial byte is discarded.
- Widths: edge_cnt compare uses 6-bit prescale-1 with no overflow (max 31).

Optional Feature:
Macro UART_RX_BREAK_DETECT_EN.
- Defined: adds output port break_det (1 bit, reset 0). When all data bits and the stop bit are 0, frame end pulses break_det for one cycle instead of stp_err/par_err; data_valid stays 0.
- Undefined: port absent; that frame reports stp_err as normal.

Decomposition:
- Package uart_rx_pkg:
  - state enum;
  - legal prescale constants PRESCALE_8/16/32;
  - is_legal_prescale function;
  - DATA_WIDTH default.
- Sub-module uart_rx_edge_bit_counter: edge_cnt and bit counter, enable/clear inputs, bit_end and last_bit outputs. The FSM, shift register and checks stay in the top module.

Test Plan:
- Basic frame: prescale=8, par_en=0, frame 0xA5 -> data_valid pulses once at the STOP bit end, p_data=0xA5, no errors.
- Even parity: prescale=16, par_en=1, par_typ=0, data 0x03 with parity bit 1 -> par_err pulse, data_valid=0, p_data unchanged.
- Framing error: prescale=32, stop bit driven 0 -> stp_err pulse; break_det instead when the macro is defined and data is 0x00.
- False start: rx_in low for 2 cycles at prescale=16, sampled_bit=1 -> return to IDLE, no pulses.
- Back-to-back and illegal prescale: 0x55 then 0xAA with no idle gap -> two data_valid pulses. prescale=12 -> never leaves IDLE.
- Reset mid-frame: rst low during DATA bit 3 -> all outputs 0 next edge; the next full frame 0x3C is received correctly.
